uart_program_loader: RTL and testbench

- Boot/program-load controller between the UART receiver and the CPU's 32-byte instruction memory.
- On a Load pulse it holds the CPU and parses a framed byte stream: a length byte, N program bytes, then a checksum byte. Program bytes are written to memory from address 0.
- On a valid frame it releases the CPU with a one-cycle start pulse. On any fault it stays in hold and reports an error code.

---
 rtl/uart_program_loader_if.sv | 30 +++
 rtl/uart_program_loader.sv | 133 +++++++++++++
 tb/tb_uart_program_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_program_loader_if.sv
// Handshake/bus bundle between the UART receiver, the program loader,
// the instruction memory write port and the CPU hold/start controls.
interface uart_program_loader_if #(
    parameter int ADDR_W = 5
);
    logic              load;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_fe;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              busy;
    logic              done;
    logic [2:0]        err;

    // Side that issues Load and delivers received bytes.
    modport master (
        output load, rx_valid, rx_data, rx_fe,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, busy, done, err
    );

    // The loader itself.
    modport slave (
        input  load, rx_valid, rx_data, rx_fe,
        output mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start, busy, done, err
    );
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: holds the CPU, parses a framed byte stream
// (length, N program bytes, additive checksum) into instruction memory
// starting at address 0, then releases the CPU with a one-cycle start pulse.
// Any fault parks the loader in FAIL with an error code until the next Load.
module uart_program_loader #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 4096
) (
    input logic                  clk,
    input logic                  rst,
    uart_program_loader_if.slave bus
);
    localparam int unsigned CAP   = 2 ** ADDR_W;
    localparam int          TMO_W = $clog2(TIMEOUT);
    // The fault fires on the cycle the idle counter would reach TIMEOUT-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_FRAME   = 3'd1;
    localparam logic [2:0] ERR_LENGTH  = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [7:0]        sum;
    logic [TMO_W-1:0]  timer;

    // Frame parser FSM with all outputs registered alongside the state.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the same pre-edge values; a blocking assignment
    // would let later statements see half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            last_idx      <= '0;
            sum           <= '0;
            timer         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_hold  <= 1'b1;
            bus.cpu_start <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= ERR_NONE;
        end else begin
            // Write strobe and start pulse are single-cycle by default.
            bus.mem_we    <= 1'b0;
            bus.cpu_start <= 1'b0;

            if (bus.load) begin
                // Load has priority over any coincident received byte.
                state        <= S_LEN;
                idx          <= '0;
                sum          <= '0;
                timer        <= '0;
                bus.cpu_hold <= 1'b1;
                bus.busy     <= 1'b1;
                bus.done     <= 1'b0;
                bus.err      <= ERR_NONE;
            end else begin
                unique case (state)
                    S_LEN, S_DATA, S_CSUM: begin
                        if (!bus.rx_valid) begin
                            if (timer == TMO_LAST) begin
                                state    <= S_FAIL;
                                bus.busy <= 1'b0;
                                bus.err  <= ERR_TIMEOUT;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end else if (bus.rx_fe) begin
                            // Corrupted byte: neither written nor summed.
                            state    <= S_FAIL;
                            bus.busy <= 1'b0;
                            bus.err  <= ERR_FRAME;
                        end else begin
                            timer <= '0;
                            if (state == S_LEN) begin
                                if (bus.rx_data != 8'd0 && {24'd0, bus.rx_data} <= CAP) begin
                                    state    <= S_DATA;
                                    last_idx <= ADDR_W'(bus.rx_data - 8'd1);
                                    idx      <= '0;
                                    sum      <= '0;
                                end else begin
                                    state    <= S_FAIL;
                                    bus.busy <= 1'b0;
                                    bus.err  <= ERR_LENGTH;
                                end
                            end else if (state == S_DATA) begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= idx;
                                bus.mem_wdata <= bus.rx_data;
                                sum           <= sum + bus.rx_data;
                                // Index stops at N-1, so a full memory never wraps.
                                if (idx == last_idx) begin
                                    state <= S_CSUM;
                                end else begin
                                    idx <= idx + 1'b1;
                                end
                            end else begin
                                bus.busy <= 1'b0;
                                if (bus.rx_data == sum) begin
                                    state         <= S_RUN;
                                    bus.cpu_hold  <= 1'b0;
                                    bus.cpu_start <= 1'b1;
                                    bus.done      <= 1'b1;
                                end else begin
                                    state   <= S_FAIL;
                                    bus.err <= ERR_CSUM;
                                end
                            end
                        end
                    end
                    // IDLE, RUN and FAIL ignore received bytes and wait for Load.
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: framing, bounds, faults,
// restart collisions and asynchronous reset, with hand-computed expectations.
module tb_uart_program_loader;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed write and start activity, recorded at the clock edge.
    int         wr_count    = 0;
    int         start_count = 0;
    logic [7:0] mem_model [32];

    // Tally memory writes and start pulses seen during each cycle.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            wr_count <= wr_count + 1;
            mem_model[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.cpu_start) start_count <= start_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe = 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        bus.rx_fe    = fe;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_fe    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int         w0;
    int         s0;
    int         cyc;
    logic [7:0] seq [5];

    initial begin
        bus.load     = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.rx_fe    = 1'b0;

        // Reset state
        idle(2);
        check("rst_hold",  bus.cpu_hold,  1);
        check("rst_we",    bus.mem_we,    0);
        check("rst_addr",  bus.mem_addr,  0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_start", bus.cpu_start, 0);
        check("rst_busy",  bus.busy,      0);
        check("rst_done",  bus.done,      0);
        check("rst_err",   bus.err,       0);
        rst = 1'b0;
        idle(1);

        // Normal load: 03, 11 22 33, checksum 66
        w0 = wr_count; s0 = start_count;
        pulse_load();
        check("n_busy", bus.busy, 1);
        check("n_hold", bus.cpu_hold, 1);
        send_byte(8'h03);
        check("n_len_nowr", bus.mem_we, 0);
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i]);
            check("n_we",    bus.mem_we,    1);
            check("n_addr",  bus.mem_addr,  i);
            check("n_wdata", bus.mem_wdata, seq[i]);
        end
        send_byte(8'h66);
        check("n_start", bus.cpu_start, 1);
        check("n_hold0", bus.cpu_hold,  0);
        check("n_done",  bus.done,      1);
        check("n_err",   bus.err,       0);
        check("n_busy0", bus.busy,      0);
        idle(1);
        check("n_start_pulse", bus.cpu_start, 0);
        check("n_done_stay",   bus.done,      1);
        idle(2);
        send_byte(8'h55);  // ignored in RUN
        check("n_wr_count",    wr_count - w0,    3);
        check("n_start_count", start_count - s0, 1);
        check("n_mem1",        mem_model[1],     8'h22);

        // Bad checksum: 02, 01 02, checksum 04 (expected 03)
        w0 = wr_count; s0 = start_count;
        pulse_load();
        check("b_hold", bus.cpu_hold, 1);
        check("b_done", bus.done, 0);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h04);
        check("b_err",  bus.err,      3);
        check("b_hold1", bus.cpu_hold, 1);
        check("b_busy", bus.busy,     0);
        idle(2);
        check("b_wr_count",    wr_count - w0,    2);
        check("b_start_count", start_count - s0, 0);
        check("b_err_hold",    bus.err,          3);

        // Length bounds: 00 and 21 rejected, 20 accepted
        w0 = wr_count;
        pulse_load();
        check("l_err_clr", bus.err, 0);
        send_byte(8'h00);
        check("l_err0", bus.err, 2);
        pulse_load();
        send_byte(8'h21);
        check("l_err21", bus.err, 2);
        idle(1);
        check("l_nowr", wr_count - w0, 0);
        w0 = wr_count;
        pulse_load();
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) send_byte(8'h01);
        check("l_last_addr", bus.mem_addr, 5'h1F);
        check("l_busy_csum", bus.busy, 1);
        send_byte(8'h20);
        check("l_done", bus.done, 1);
        check("l_err",  bus.err,  0);
        idle(1);
        check("l_wr_count", wr_count - w0, 32);
        check("l_mem31",    mem_model[31], 8'h01);

        // Frame error on the second data byte
        w0 = wr_count;
        pulse_load();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22, 1'b1);
        check("f_err",  bus.err,    1);
        check("f_we",   bus.mem_we, 0);
        check("f_hold", bus.cpu_hold, 1);
        idle(1);
        check("f_wr_count", wr_count - w0, 1);

        // Timeout: nothing after the length byte
        pulse_load();
        send_byte(8'h04);
        cyc = 0;
        while (bus.err != 3'd4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t_cycles", cyc, 15);
        check("t_err",    bus.err, 4);
        check("t_busy",   bus.busy, 0);

        // Restart collision: Load coincident with a data byte
        w0 = wr_count;
        pulse_load();
        send_byte(8'h03);
        send_byte(8'hAA);
        @(negedge clk);
        bus.load     = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hBB;
        @(negedge clk);
        bus.load     = 1'b0;
        bus.rx_valid = 1'b0;
        check("c_we",   bus.mem_we, 0);
        check("c_busy", bus.busy,   1);
        check("c_err",  bus.err,    0);
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h0B);
        check("c_done", bus.done, 1);
        check("c_hold", bus.cpu_hold, 0);
        idle(1);
        check("c_wr_count", wr_count - w0, 3);
        check("c_mem0",     mem_model[0],  8'h05);

        // Load in RUN re-asserts hold next cycle
        pulse_load();
        check("r_hold", bus.cpu_hold, 1);
        check("r_done", bus.done,     0);
        check("r_busy", bus.busy,     1);

        // Asynchronous reset mid-DATA
        send_byte(8'h04);
        send_byte(8'h01);
        check("a_we_before", bus.mem_we, 1);
        #2 rst = 1'b1;
        #1;
        check("a_we",    bus.mem_we,    0);
        check("a_hold",  bus.cpu_hold,  1);
        check("a_busy",  bus.busy,      0);
        check("a_addr",  bus.mem_addr,  0);
        check("a_wdata", bus.mem_wdata, 0);
        check("a_err",   bus.err,       0);
        idle(1);
        rst = 1'b0;
        idle(2);
        check("a_idle_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
